// File: rtl/dpram_burst_reader.sv
// Burst read initiator for a dual-port RAM: walks consecutive words through one read
// port and streams them in order on valid/ready, using a 2-entry buffer for RAM latency.
module dpram_burst_reader #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len_m1,
    output logic          busy,
    output logic          done,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_do,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [AW-1:0]   base_r;
    logic [AW-1:0]   len_r;
    logic [AW:0]     issued_r;
    logic [AW:0]     accepted_r;
    logic            inflight_r;
    logic [DW-1:0]   head_r;
    logic [DW-1:0]   tail_r;
    logic [1:0]      count_r;
    logic [1:0]      count_nxt_s;
    logic            valid_r;
    logic            done_r;

    logic            pop_s;
    logic [2:0]      occ_s;
    logic            start_ok_s;
    logic            ram_en_s;
    logic            last_issue_s;
    logic            last_pop_s;

    // Handshake and issue-room bookkeeping; occupancy counts the word already in flight
    always_comb begin
        pop_s        = valid_r & m_ready;
        occ_s        = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        start_ok_s   = (state_r == S_IDLE) && start && !done_r;
        ram_en_s     = (state_r == S_ISSUE) && (occ_s < 3'd2);
        last_issue_s = ram_en_s && (issued_r == {1'b0, len_r});
        last_pop_s   = (state_r == S_DRAIN) && pop_s && (accepted_r == {1'b0, len_r});
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) state_nxt_s = S_ISSUE;
                else            state_nxt_s = S_IDLE;
            end
            S_ISSUE: begin
                if (last_issue_s) state_nxt_s = S_DRAIN;
                else              state_nxt_s = S_ISSUE;
            end
            S_DRAIN: begin
                if (last_pop_s) state_nxt_s = S_IDLE;
                else            state_nxt_s = S_DRAIN;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM outputs; address wraps naturally modulo the RAM depth
    always_comb begin
        busy     = (state_r != S_IDLE);
        ram_en   = ram_en_s;
        ram_addr = base_r + issued_r[AW-1:0];
        done     = done_r;
        m_valid  = valid_r;
        m_data   = head_r;
    end

    // Burst parameters, issue/accept counters and in-flight flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r     <= {AW{1'b0}};
            len_r      <= {AW{1'b0}};
            issued_r   <= {(AW+1){1'b0}};
            accepted_r <= {(AW+1){1'b0}};
            inflight_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (start_ok_s) begin
                base_r     <= base_addr;
                len_r      <= len_m1;
                issued_r   <= {(AW+1){1'b0}};
                accepted_r <= {(AW+1){1'b0}};
            end else begin
                if (ram_en_s) issued_r   <= issued_r + {{AW{1'b0}}, 1'b1};
                if (pop_s)    accepted_r <= accepted_r + {{AW{1'b0}}, 1'b1};
            end
            inflight_r <= ram_en_s;
            done_r     <= last_pop_s;
        end
    end

    // Buffer occupancy after this cycle's push (in-flight return) and pop
    always_comb begin
        count_nxt_s = count_r;
        case ({inflight_r, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Two-entry output FIFO; head register drives the stream directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {DW{1'b0}};
            tail_r  <= {DW{1'b0}};
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) head_r <= ram_do;
                    else                 tail_r <= ram_do;
                end
                2'b01: head_r <= tail_r;
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= ram_do;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= ram_do;
                    end
                end
                default: ;
            endcase
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
        end
    end

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Scoreboard bench for dpram_burst_reader: a behavioural RAM feeds the read port and a
// monitor compares each delivered word against words queued when the burst starts.
module tb_dpram_burst_reader;
    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] len_m1;
    logic          busy, done, ram_en, m_valid, m_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_do, m_data;

    logic [DW-1:0] mem [64];
    logic [DW-1:0] exp_q [$];
    int n_cmp = 0;
    int n_err = 0;
    int outst = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = 16'h0000;

    dpram_burst_reader #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len_m1(len_m1),
        .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr), .ram_do(ram_do),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // RAM read port: one-cycle latency
    always @(posedge clk) if (ram_en) ram_do <= mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard pop, hold-stability and issue-room rule
    always @(negedge clk) begin
        int pop_now;
        if (!rst_n) begin
            outst = 0;
            prev_stall = 1'b0;
        end else begin
            pop_now = (m_valid && m_ready) ? 1 : 0;
            if (prev_stall) chk("data_stable", m_data, prev_data);
            if (pop_now == 1) begin
                if (exp_q.size() == 0) chk("unexpected_word", m_data, 32'hDEAD_BEEF);
                else chk("word", m_data, exp_q.pop_front());
            end
            if (ram_en) chk("issue_room", (outst - pop_now) < 2, 1);
            outst = outst + (ram_en ? 1 : 0) - pop_now;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        logic [AW-1:0] a;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len_m1 = l;
        for (int k = 0; k <= int'(l); k++) begin
            a = b + k[AW-1:0];
            exp_q.push_back(mem[a]);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        bit seen = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                if (toggle) m_ready = ~m_ready;
            end
        end
        chk("done_seen", seen, 1'b1);
        chk("all_words_out", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h5A00 + 16'(i) * 16'h0103;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len_m1 = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0); chk("rst_en", ram_en, 0); chk("rst_addr", ram_addr, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: base 4, len 4, cycle-exact latency
        @(posedge clk); #1;
        start = 1'b1; base_addr = 6'h04; len_m1 = 6'd3;
        for (int k = 4; k < 8; k++) exp_q.push_back(mem[k]);
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (c == 1) start = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("t1_en_c%0d", c), ram_en, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk($sformatf("t1_addr_c%0d", c), ram_addr, c + 3);
            chk($sformatf("t1_valid_c%0d", c), m_valid, (c >= 3 && c <= 6));
            chk($sformatf("t1_busy_c%0d", c), busy, (c >= 1 && c <= 6));
            chk($sformatf("t1_done_c%0d", c), done, (c == 7));
        end

        // 2: address wrap past the top
        do_start(6'h3E, 6'd3);
        wait_done(1'b0);

        // 3: full RAM with toggling ready
        do_start(6'h00, 6'd63);
        wait_done(1'b1);
        m_ready = 1'b1;

        // 4: long stall mid-burst
        do_start(6'h08, 6'd15);
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t4_stall_en", ram_en, 0);
        chk("t4_stall_valid", m_valid, 1);
        @(posedge clk); #1 m_ready = 1'b1;
        wait_done(1'b0);

        // 5: reset mid-burst
        do_start(6'h00, 6'd15);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0); chk("t5_done", done, 0); chk("t5_valid", m_valid, 0);
        chk("t5_data", m_data, 0); chk("t5_en", ram_en, 0); chk("t5_addr", ram_addr, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_no_done", done, 0);
            chk("t5_idle", busy, 0);
        end
        do_start(6'h10, 6'd2);
        wait_done(1'b0);

        // 6: start ignored while busy and in the done cycle; single-word burst
        do_start(6'h20, 6'd5);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 6'h00; len_m1 = 6'd1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(1'b0);
        start = 1'b1; base_addr = 6'h30; len_m1 = 6'd2;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_done_start_busy", busy, 0);
            chk("t6_done_start_en", ram_en, 0);
        end
        do_start(6'h09, 6'd0);
        wait_done(1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
